demux_buf: RTL and testbench
============================

DEMUX_BUF -- requirements
Module: demux_buf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data word width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port d, input, WIDTH bits: the input data word.
REQ-005 The block SHALL have port d_valid, input, 1 bit: the input word is present.
REQ-006 The block SHALL have port d_ready, output, 1 bit: the block accepts the input word this cycle.
REQ-007 The block SHALL have port sel, input, 1 bit: destination lane (0 = lane A, 1 = lane B), qualified by d_valid.
REQ-008 The block SHALL have ports oa and ob, outputs, WIDTH bits each: lane A and lane B head-of-queue data.
REQ-009 The block SHALL have ports oa_valid and ob_valid, outputs, 1 bit each: the lane head word is valid.
REQ-010 The block SHALL have ports oa_ready and ob_ready, inputs, 1 bit each: the downstream consumer takes the lane head.
REQ-011 The block SHALL have ports cnt_a and cnt_b, outputs, 8 bits each: saturating count of words delivered per lane.

Function
REQ-012 Each lane SHALL contain an independent 2-entry FIFO (two data registers, 1-bit read and write pointers, 2-bit occupancy).
REQ-013 d_ready SHALL equal "selected lane FIFO not full, or selected lane FIFO full and its head popped this cycle"; it SHALL be combinational from sel, occupancy and the lane ready input.
REQ-014 An input transfer SHALL occur when d_valid && d_ready; the word SHALL be written to the lane given by sel in that cycle.
REQ-015 A lane pop SHALL occur when ox_valid && ox_ready; ox_valid SHALL be 1 iff the lane occupancy is nonzero.
REQ-016 ox SHALL present the head entry directly from the storage register (registered path, no bypass); the minimum latency from input transfer to ox_valid SHALL be 1 cycle.
REQ-017 Simultaneous push and pop on the same lane SHALL leave occupancy unchanged and SHALL be legal when the lane is full (pop frees the slot) and when the lane holds 1 entry.
REQ-018 A push to one lane SHALL never alter the occupancy, data or valid of the other lane.
REQ-019 Words SHALL leave each lane in arrival order; pointers SHALL wrap 1 -> 0.
REQ-020 When d_valid=0, sel and d SHALL be ignored and no FIFO SHALL change except by pops.
REQ-021 A push while the selected lane is full and not popping SHALL NOT occur (d_ready=0); the word SHALL remain stalled upstream, not dropped.
REQ-022 ox contents while ox_valid=0 SHALL be don't-care, but SHALL NOT contain X after reset.
REQ-023 cnt_x SHALL increment by 1 on each pop of lane x and SHALL saturate at 255.

Reset
REQ-024 When rst=1 at a rising edge, all occupancies, pointers and counters SHALL become 0, oa_valid=ob_valid=0, oa=ob=0, cnt_a=cnt_b=0.
REQ-025 While rst=1, d_ready SHALL be 0; words presented during reset SHALL be discarded.
REQ-026 Reset asserted mid-operation SHALL flush all queued words in both lanes in the same edge; no stale word SHALL appear after rst drops.
REQ-027 The first input transfer SHALL be possible in the first cycle with rst=0.

Verification
REQ-028 Routing: after reset, push d=0x11 sel=0, then d=0x22 sel=1, both readies 1 -> oa=0x11 oa_valid for 1 cycle, ob=0x22 ob_valid for 1 cycle, cnt_a=1, cnt_b=1.
REQ-029 Full/backpressure: oa_ready=0, push 0x01,0x02,0x03 to lane A -> first two accepted, d_ready=0 for 0x03; raise oa_ready -> outputs 0x01,0x02,0x03 in order.
REQ-030 Lane independence: lane A full with oa_ready=0, push 0x44 sel=1 -> d_ready=1, ob=0x44 next cycle, lane A contents unchanged.
REQ-031 Full with simultaneous pop: lane B full (0x0A,0x0B), ob_ready=1 and push 0x0C sel=1 same cycle -> accepted, ob sequence 0x0A,0x0B,0x0C, occupancy never exceeds 2.
REQ-032 Mid-operation reset: both lanes holding 2 words, assert rst 1 cycle -> oa_valid=ob_valid=0, cnt_a=cnt_b=0, no old word emitted afterward.
REQ-033 Saturation: 300 pops on lane A -> cnt_a=255 and holds at 255.

Source files
------------

// File: rtl/demux_buf.sv
// Two-lane demultiplexing buffer: each input word is steered by sel into one of two
// independent 2-entry FIFOs, each with its own valid/ready output and a saturating pop counter.

module demux_buf_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             full,
    output logic [7:0]       cnt
);
    logic [WIDTH-1:0] mem_q [2];
    logic             wptr_q;
    logic             rptr_q;
    logic [1:0]       occ_q;
    logic [1:0]       occ_d;
    logic [7:0]       cnt_q;
    logic [7:0]       cnt_d;
    logic             pop;

    assign valid = (occ_q != 2'd0);
    assign full  = (occ_q == 2'd2);
    assign pop   = valid && pop_ready;
    // Head comes straight from storage, so a pushed word is visible one cycle later.
    assign head  = mem_q[rptr_q];
    assign cnt   = cnt_q;

    always_comb begin
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + 2'd1;
        end else if (pop && !push) begin
            occ_d = occ_q - 2'd1;
        end
        cnt_d = cnt_q;
        if (pop && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            occ_q    <= 2'd0;
            cnt_q    <= 8'd0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            occ_q <= occ_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

module demux_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic             d_ready,
    input  logic             sel,
    output logic [WIDTH-1:0] oa,
    output logic [WIDTH-1:0] ob,
    output logic             oa_valid,
    output logic             ob_valid,
    input  logic             oa_ready,
    input  logic             ob_ready,
    output logic [7:0]       cnt_a,
    output logic [7:0]       cnt_b
);
    // Handshake: a transfer happens on any edge where valid && ready; ready never
    // depends on valid, and a full lane accepts only when its head leaves the same cycle.
    logic full_a;
    logic full_b;
    logic push_a;
    logic push_b;
    logic room_a;
    logic room_b;

    assign room_a  = !full_a || oa_ready;
    assign room_b  = !full_b || ob_ready;
    assign d_ready = !rst && (sel ? room_b : room_a);
    assign push_a  = d_valid && d_ready && !sel;
    assign push_b  = d_valid && d_ready && sel;

    demux_buf_lane #(.WIDTH(WIDTH)) u_lane_a (
        .clk       (clk),
        .rst       (rst),
        .push      (push_a),
        .wdata     (d),
        .pop_ready (oa_ready),
        .head      (oa),
        .valid     (oa_valid),
        .full      (full_a),
        .cnt       (cnt_a)
    );

    demux_buf_lane #(.WIDTH(WIDTH)) u_lane_b (
        .clk       (clk),
        .rst       (rst),
        .push      (push_b),
        .wdata     (d),
        .pop_ready (ob_ready),
        .head      (ob),
        .valid     (ob_valid),
        .full      (full_b),
        .cnt       (cnt_b)
    );
endmodule

// File: tb/tb_demux_buf.sv
// Directed bench for demux_buf: routing, backpressure, lane independence,
// full-with-pop, mid-operation reset and counter saturation.

module tb_demux_buf;
    logic       clk;
    logic       rst;
    logic [7:0] d;
    logic       d_valid;
    logic       d_ready;
    logic       sel;
    logic [7:0] oa;
    logic [7:0] ob;
    logic       oa_valid;
    logic       ob_valid;
    logic       oa_ready;
    logic       ob_ready;
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;

    int checks = 0;
    int errors = 0;

    demux_buf #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .d        (d),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .sel      (sel),
        .oa       (oa),
        .ob       (ob),
        .oa_valid (oa_valid),
        .ob_valid (ob_valid),
        .oa_ready (oa_ready),
        .ob_ready (ob_ready),
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle at the falling edge where inputs change and outputs are sampled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] w);
        d_valid = v;
        sel     = s;
        d       = w;
        #1;
    endtask

    initial begin
        rst = 1'b1; d = 8'hEE; d_valid = 1'b1; sel = 1'b0;
        oa_ready = 1'b1; ob_ready = 1'b1;
        step();
        step();
        chk("rst_d_ready", d_ready, 0);
        chk("rst_oa_valid", oa_valid, 0);
        chk("rst_ob_valid", ob_valid, 0);
        chk("rst_oa", oa, 0);
        chk("rst_ob", ob, 0);
        chk("rst_cnt_a", cnt_a, 0);
        chk("rst_cnt_b", cnt_b, 0);

        // Routing: first transfer in the first cycle out of reset
        rst = 1'b0;
        drive(1, 0, 8'h11);
        chk("route_d_ready_a", d_ready, 1);
        step();
        drive(1, 1, 8'h22);
        chk("route_oa_valid", oa_valid, 1);
        chk("route_oa", oa, 8'h11);
        chk("route_ob_valid0", ob_valid, 0);
        step();
        drive(0, 0, 8'h99);
        chk("route_oa_gone", oa_valid, 0);
        chk("route_ob_valid", ob_valid, 1);
        chk("route_ob", ob, 8'h22);
        chk("route_cnt_a", cnt_a, 1);
        step();
        chk("route_ob_gone", ob_valid, 0);
        chk("route_cnt_b", cnt_b, 1);

        // Backpressure on lane A
        oa_ready = 1'b0;
        drive(1, 0, 8'h01);
        chk("bp_rdy1", d_ready, 1);
        step();
        drive(1, 0, 8'h02);
        chk("bp_rdy2", d_ready, 1);
        step();
        drive(1, 0, 8'h03);
        chk("bp_rdy3_stall", d_ready, 0);
        chk("bp_head", oa, 8'h01);
        step();
        chk("bp_still_stall", d_ready, 0);
        chk("bp_head_hold", oa, 8'h01);

        // Lane independence while A is full
        drive(1, 1, 8'h44);
        chk("ind_rdy_b", d_ready, 1);
        step();
        chk("ind_ob_valid", ob_valid, 1);
        chk("ind_ob", ob, 8'h44);
        chk("ind_oa_kept", oa, 8'h01);
        chk("ind_oa_valid", oa_valid, 1);

        // Release A with the stalled word pushed into the slot freed by the pop
        oa_ready = 1'b1;
        drive(1, 0, 8'h03);
        chk("bp_rdy3_pop", d_ready, 1);
        step();
        drive(0, 0, 8'h00);
        chk("bp_out2", oa, 8'h02);
        chk("ind_ob_gone", ob_valid, 0);
        step();
        chk("bp_out3", oa, 8'h03);
        chk("bp_out3_valid", oa_valid, 1);
        step();
        chk("bp_empty", oa_valid, 0);
        chk("bp_cnt_a", cnt_a, 4);
        chk("bp_cnt_b", cnt_b, 2);

        // Lane B full with simultaneous pop and push
        ob_ready = 1'b0;
        drive(1, 1, 8'h0A);
        step();
        drive(1, 1, 8'h0B);
        step();
        drive(1, 1, 8'h0C);
        chk("fp_stall", d_ready, 0);
        chk("fp_head_a", ob, 8'h0A);
        ob_ready = 1'b1;
        #1;
        chk("fp_rdy_pop", d_ready, 1);
        step();
        drive(0, 1, 8'h00);
        chk("fp_head_b", ob, 8'h0B);
        step();
        chk("fp_head_c", ob, 8'h0C);
        chk("fp_valid_c", ob_valid, 1);
        step();
        chk("fp_empty", ob_valid, 0);
        chk("fp_cnt_b", cnt_b, 5);
        chk("fp_oa_quiet", oa_valid, 0);

        // Mid-operation reset flushes both lanes
        oa_ready = 1'b0; ob_ready = 1'b0;
        drive(1, 0, 8'h5A); step();
        drive(1, 0, 8'h5B); step();
        drive(1, 1, 8'h6A); step();
        drive(1, 1, 8'h6B); step();
        drive(0, 0, 8'h00);
        chk("mr_pre_a", oa_valid, 1);
        chk("mr_pre_b", ob_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mr_oa_valid", oa_valid, 0);
        chk("mr_ob_valid", ob_valid, 0);
        chk("mr_cnt_a", cnt_a, 0);
        chk("mr_cnt_b", cnt_b, 0);
        chk("mr_oa", oa, 0);
        chk("mr_ob", ob, 0);
        oa_ready = 1'b1; ob_ready = 1'b1;
        drive(0, 1, 8'h77);
        step();
        step();
        chk("mr_no_stale_a", oa_valid, 0);
        chk("mr_no_stale_b", ob_valid, 0);
        chk("mr_cnt_a_after", cnt_a, 0);

        // Saturation: stream words through lane A, one pop per edge after the first
        for (int i = 1; i <= 300; i++) begin
            drive(1, 0, i[7:0]);
            step();
            if (i == 100) chk("sat_head_100", oa, 8'd100);
            if (i == 255) chk("sat_cnt_254", cnt_a, 254);
            if (i == 256) chk("sat_cnt_255", cnt_a, 255);
        end
        drive(0, 0, 8'h00);
        step();
        chk("sat_cnt_300", cnt_a, 255);
        chk("sat_empty", oa_valid, 0);
        step();
        step();
        chk("sat_hold", cnt_a, 255);
        chk("sat_cnt_b", cnt_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
